// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter and its helpers.
//   arb_state_t  : arbiter FSM encoding (IDLE, BUSY, RELEASE)
//   BUS_W        : default bus/data width
//   ARB_N_REQ    : default number of requesting clients
//   ARB_MAX_HOLD : default maximum BUSY cycles per grant
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int BUS_W        = 16;
  localparam int ARB_N_REQ    = 4;
  localparam int ARB_MAX_HOLD = 8;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder.
// Finds the first set request bit searching upward from ptr, wrapping
// modulo N. Shared by any scheduler in the datapath needing round-robin.
//   req : request vector (N bits)
//   ptr : search start index (must be < N)
//   any : at least one request is set
//   idx : index of the winning request (0 when any=0)
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IDX_W = $clog2(N);

  // One spare bit so ptr + offset cannot overflow before the wrap.
  logic [IDX_W:0] cand;

  always_comb begin
    any  = |req;
    idx  = '0;
    cand = '0;
    // Walk offsets from farthest to nearest so the nearest hit is the
    // last assignment and therefore wins.
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N)) begin
        cand = cand - (IDX_W + 1)'(N);
      end
      if (req[cand[IDX_W-1:0]]) begin
        idx = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter and sequencer for the shared bus.
// Grants one client at a time, drives its one-hot output-enable, and
// captures the owner's word onto a registered bus output. A RELEASE dead
// cycle separates owners; tenure is capped at MAX_HOLD BUSY cycles.
//   CLK       : system clock, rising edge
//   RST_N     : asynchronous active-low reset
//   req       : per-client level request
//   done      : per-client end-of-transfer pulse (owner's bit only)
//   data_in   : client words, client i at [i*DATA_W +: DATA_W]
//   oe        : one-hot (or zero) output-enable
//   grant_id  : current owner index, valid while oe != 0
//   bus_data  : registered bus word
//   bus_valid : bus_data holds a word captured from the owner
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_REQ    = ARB_N_REQ,
  parameter int DATA_W   = BUS_W,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        done,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  output logic [N_REQ-1:0]        oe,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic [DATA_W-1:0]       bus_data,
  output logic                    bus_valid
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t         state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [N_REQ-1:0]   oe_q;
  logic [IDX_W-1:0]   grant_id_q;
  logic [DATA_W-1:0]  bus_data_q;
  logic               bus_valid_q;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   grant_oe_d;
  logic [IDX_W-1:0]   ptr_d;
  logic               release_d;

  // Unpack the flat client bus into one word per client for the capture mux.
  logic [DATA_W-1:0]  word_in [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign word_in[gi] = data_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    grant_oe_d           = '0;
    grant_oe_d[pick_idx] = 1'b1;
  end

  // Next search start is the client after the one being released.
  assign ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

  // Any of: owner finished, owner withdrew, or tenure limit reached.
  assign release_d = done[owner_q] | ~req[owner_q] | (hold_cnt_q == HOLD_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      oe_q        <= '0;
      grant_id_q  <= '0;
      bus_data_q  <= '0;
      bus_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q    <= BUSY;
            owner_q    <= pick_idx;
            grant_id_q <= pick_idx;
            oe_q       <= grant_oe_d;
            hold_cnt_q <= '0;
          end
        end
        BUSY: begin
          // Capture continues on the releasing edge: that word is the last valid one.
          bus_data_q  <= word_in[owner_q];
          bus_valid_q <= 1'b1;
          hold_cnt_q  <= hold_cnt_q + HOLD_W'(1);
          if (release_d) begin
            state_q <= RELEASE;
            oe_q    <= '0;
            ptr_q   <= ptr_d;
          end
        end
        RELEASE: begin
          state_q     <= IDLE;
          bus_valid_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          oe_q    <= '0;
        end
      endcase
    end
  end

  assign oe        = oe_q;
  assign grant_id  = grant_id_q;
  assign bus_data  = bus_data_q;
  assign bus_valid = bus_valid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic        CLK;
  logic        RST_N;
  logic [3:0]  req;
  logic [3:0]  done;
  logic [63:0] data_in;
  logic [3:0]  oe;
  logic [1:0]  grant_id;
  logic [15:0] bus_data;
  logic        bus_valid;

  int tests_run;
  int tests_failed;

  bus_arbiter #(
    .N_REQ    (4),
    .DATA_W   (16),
    .MAX_HOLD (8)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req       (req),
    .done      (done),
    .data_in   (data_in),
    .oe        (oe),
    .grant_id  (grant_id),
    .bus_data  (bus_data),
    .bus_valid (bus_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_word(input int i, input logic [15:0] w);
    data_in[i*16 +: 16] = w;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    req   = '0;
    done  = '0;
    #2;
    RST_N = 1'b1;
  endtask

  initial begin
    int exp_order [5];
    logic [3:0] m;
    exp_order = '{0, 1, 2, 3, 0};
    tests_run    = 0;
    tests_failed = 0;
    RST_N   = 1'b0;
    req     = '0;
    done    = '0;
    data_in = '0;

    // Reset state
    #12;
    check_val("rst_oe", 32'(oe), 32'h0);
    check_val("rst_grant_id", 32'(grant_id), 32'h0);
    check_val("rst_bus_data", 32'(bus_data), 32'h0);
    check_val("rst_bus_valid", 32'(bus_valid), 32'h0);
    RST_N = 1'b1;

    // Single transfer: client 2, done in 3rd BUSY cycle
    set_word(2, 16'hA5A5);
    req = 4'b0100;
    tick();
    check_val("t2_grant_oe", 32'(oe), 32'h4);
    check_val("t2_grant_id", 32'(grant_id), 32'h2);
    check_val("t2_first_bv", 32'(bus_valid), 32'h0);
    tick();
    check_val("t2_busy2_oe", 32'(oe), 32'h4);
    check_val("t2_busy2_data", 32'(bus_data), 32'hA5A5);
    check_val("t2_busy2_bv", 32'(bus_valid), 32'h1);
    tick();
    check_val("t2_busy3_oe", 32'(oe), 32'h4);
    done = 4'b0100;
    tick();
    done = '0;
    req  = '0;
    check_val("t2_rel_oe", 32'(oe), 32'h0);
    check_val("t2_rel_bv", 32'(bus_valid), 32'h1);
    check_val("t2_rel_data", 32'(bus_data), 32'hA5A5);
    tick();
    check_val("t2_idle_oe", 32'(oe), 32'h0);
    check_val("t2_idle_bv", 32'(bus_valid), 32'h0);

    // Reset mid-BUSY: client 2 owning, reset asserted between edges
    set_word(2, 16'h1234);
    req = 4'b0100;
    tick();
    tick();
    check_val("t1_pre_bv", 32'(bus_valid), 32'h1);
    check_val("t1_pre_data", 32'(bus_data), 32'h1234);
    #2;
    RST_N = 1'b0;
    #1;
    check_val("t1_rst_oe", 32'(oe), 32'h0);
    check_val("t1_rst_bv", 32'(bus_valid), 32'h0);
    check_val("t1_rst_data", 32'(bus_data), 32'h0);
    check_val("t1_rst_gid", 32'(grant_id), 32'h0);
    #1;
    RST_N = 1'b1;
    req   = 4'b0001;
    tick();
    check_val("t1_after_oe", 32'(oe), 32'h1);
    check_val("t1_after_gid", 32'(grant_id), 32'h0);
    req = '0;
    tick();
    tick();

    // Round-robin fairness: all request, each owner done after 1 cycle
    do_reset();
    for (int c = 0; c < 4; c++) set_word(c, 16'hC000 + 16'(c));
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      m = 4'(1 << exp_order[n]);
      tick();
      check_val($sformatf("rr%0d_oe", n), 32'(oe), 32'(m));
      check_val($sformatf("rr%0d_gid", n), 32'(grant_id), 32'(exp_order[n]));
      done = m;
      tick();
      done = '0;
      check_val($sformatf("rr%0d_rel_oe", n), 32'(oe), 32'h0);
      check_val($sformatf("rr%0d_rel_data", n), 32'(bus_data), 32'h0000C000 + 32'(exp_order[n]));
      tick();
      check_val($sformatf("rr%0d_idle_oe", n), 32'(oe), 32'h0);
    end
    req = '0;
    tick();

    // Hold limit: clients 0 and 1 request forever, no done
    do_reset();
    req = 4'b0011;
    tick();
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("hold0_c%0d_oe", i), 32'(oe), 32'h1);
      tick();
    end
    check_val("hold0_rel_oe", 32'(oe), 32'h0);
    tick();
    check_val("hold0_idle_oe", 32'(oe), 32'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("hold1_c%0d_oe", i), 32'(oe), 32'h2);
      tick();
    end
    check_val("hold1_rel_oe", 32'(oe), 32'h0);
    tick();
    check_val("hold1_idle_oe", 32'(oe), 32'h0);
    tick();
    check_val("hold_regrant_oe", 32'(oe), 32'h1);
    check_val("hold_regrant_gid", 32'(grant_id), 32'h0);
    req = '0;
    tick();
    tick();

    // Non-owner done ignored, then owner drops request
    do_reset();
    req = 4'b0010;
    tick();
    check_val("t5_gid", 32'(grant_id), 32'h1);
    done = 4'b1000;
    tick();
    done = '0;
    check_val("t5_nonowner_done_oe", 32'(oe), 32'h2);
    req = '0;
    tick();
    check_val("t5_drop_rel_oe", 32'(oe), 32'h0);
    req = 4'b0111;
    tick();
    check_val("t5_idle_oe", 32'(oe), 32'h0);
    tick();
    check_val("t5_ptr2_oe", 32'(oe), 32'h4);
    check_val("t5_ptr2_gid", 32'(grant_id), 32'h2);
    req = '0;
    tick();
    tick();

    // Data tracking: owner 0 steps 1,2,3; other clients busy with noise
    do_reset();
    set_word(0, 16'h0001);
    set_word(1, 16'hFFFF);
    set_word(2, 16'hEEEE);
    set_word(3, 16'hDDDD);
    req = 4'b0001;
    tick();
    for (int v = 1; v <= 3; v++) begin
      tick();
      check_val($sformatf("t6_data%0d", v), 32'(bus_data), 32'(v));
      check_val($sformatf("t6_bv%0d", v), 32'(bus_valid), 32'h1);
      set_word(0, 16'(v + 1));
      set_word(1, 16'hF000 + 16'(v));
    end
    req = '0;
    tick();
    tick();
    check_val("t6_end_bv", 32'(bus_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and sequencer for the shared 16-bit datapath bus. Up to `N_REQ` clients each own a 16-bit driver register. The arbiter grants the bus to one client at a time, drives that client's one-hot output-enable, and captures the granted word onto a registered bus output. A dead cycle between owners guarantees no two drivers are ever enabled together, and a hold limit bounds each tenure so no client starves the others.

## Interface
Parameters:
- `N_REQ`, 4, number of requesting clients (2..8)
- `DATA_W`, 16, bus/data width
- `MAX_HOLD`, 8, maximum consecutive BUSY cycles per grant (≥1)

Ports:
- `CLK`  in  1  system clock, rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  per-client bus request, level-sensitive
- `done`  in  N_REQ  per-client end-of-transfer pulse; only the owner's bit is honoured
- `data_in`  in  N_REQ*DATA_W  client words; client i occupies bits [i*DATA_W +: DATA_W]
- `oe`  out  N_REQ  one-hot (or zero) output-enable to the client driver registers
- `grant_id`  out  $clog2(N_REQ)  index of the current owner, valid while `oe != 0`
- `bus_data`  out  DATA_W  registered bus word
- `bus_valid`  out  1  `bus_data` holds a word captured from the owner

## Operation
- FSM states:
  - IDLE: `oe=0`.
  - BUSY: `oe` = one-hot(owner).
  - RELEASE: `oe=0`, one dead cycle.
- IDLE → BUSY when `req != 0`. Winner is the first set `req` bit searching from `ptr` upward, wrapping modulo N_REQ. Winner is latched into `owner`; `hold_cnt` ← 0.
- In BUSY, on every edge:
  - `bus_data` ← `data_in[owner]`
  - `bus_valid` ← 1
  - `hold_cnt` ← `hold_cnt` + 1
- BUSY → RELEASE when any of the following holds at the edge (OR'd):
  - `done[owner]=1`
  - `req[owner]=0`
  - `hold_cnt == MAX_HOLD-1`
- On entry to RELEASE: `ptr` ← (owner+1) mod N_REQ. The capture that happens on that same edge is the last valid word.
- RELEASE → IDLE unconditionally. `bus_valid` ← 0 on the RELEASE→IDLE edge.
- `ptr` changes only on BUSY→RELEASE, so a lone requester is re-granted after every RELEASE.
- `done` bits from non-owners and `done` in IDLE/RELEASE are ignored.
- `hold_cnt` width: $clog2(MAX_HOLD)+1. It never wraps because the forced release fires first.
- Reset (async, any state, including mid-tenure):
  - state=IDLE, `oe=0`, `grant_id=0`, `bus_data=0`, `bus_valid=0`, `ptr=0`, `owner=0`, `hold_cnt=0`
  - Release is immediate. No dead cycle is required after reset.

## Timing
- All outputs are registered. There are no combinational input→output paths.
- Grant latency: `req` seen high at edge k → `oe`/`grant_id` valid after edge k, i.e. state=BUSY during cycle k+1.
- Data latency: the first `bus_valid=1` appears after edge k+1 and carries the `data_in[owner]` value present during cycle k+1.
- Tenure: `oe` is high for at most MAX_HOLD cycles.
- Gap: at least one cycle of `oe=0` between any two grants.
- Minimum turnaround (grant, immediate done, next grant) is 3 cycles: BUSY, RELEASE, IDLE.
- `bus_valid` stays high through the RELEASE cycle, then falls.

## Structure
- Shared package `bus_arb_pkg`:
  - state encoding enum `arb_state_t` {IDLE, BUSY, RELEASE}
  - default constants `BUS_W=16`, `ARB_N_REQ=4`, `ARB_MAX_HOLD=8`
- Sub-module `rr_pick`: combinational rotate-priority encoder.
  - inputs: `req`, `ptr`
  - outputs: `any`, `idx`
  - Reusable by other schedulers in the datapath.
- Top level holds the FSM, `owner`/`ptr`/`hold_cnt` registers, and the `data_in` capture mux.

## Test plan
1. Reset mid-BUSY:
   - Stimulus: client 2 granted, assert `RST_N=0` between edges.
   - Required: `oe=0`, `bus_valid=0`, `bus_data=16'h0000` immediately. After reset, `req=4'b0001` grants client 0.
2. Single transfer:
   - Stimulus: `req=4'b0100`, `data_in[2]=16'hA5A5`, `done[2]` pulsed in the 3rd BUSY cycle.
   - Required: `oe=4'b0100` for exactly 3 cycles, `bus_data=16'hA5A5` with `bus_valid=1`, one RELEASE cycle with `oe=0`, then IDLE.
3. Round-robin fairness:
   - Stimulus: `req=4'b1111` held, each owner pulses `done` after 1 cycle.
   - Required: grant order 0,1,2,3,0 with `oe=0` between every pair.
4. Hold limit:
   - Stimulus: `req=4'b0011` held, `done` never asserted.
   - Required: client 0 gets exactly 8 `oe` cycles, then client 1 gets 8, then client 0 again.
5. Non-owner done and request drop:
   - Stimulus: owner 1, `done[3]` pulsed → no effect; then `req[1]` dropped.
   - Required: release on that edge, and `ptr=2`.
6. Data tracking:
   - Stimulus: owner 0, `data_in[0]` steps 16'h0001, 16'h0002, 16'h0003 on successive cycles.
   - Required: `bus_data` shows the same sequence one cycle later. Words on other clients' `data_in` never appear on `bus_data`.
